// File: rtl/beat_sequencer_if.sv
// Transport command and status bundle between a controller and beat_sequencer.
// valid/ready: none; commands are single-cycle pulses sampled on the rising edge, status is registered.
interface beat_sequencer_if;
    logic        play;
    logic        pause;
    logic        stop;
    logic        loop_en;
    logic [1:0]  speed;
    logic [11:0] ibeatNum;
    logic        part;
    logic        playing;
    logic        beat_tick;
    logic        song_done;
    logic [1:0]  state;

    modport master (
        output play, pause, stop, loop_en, speed,
        input  ibeatNum, part, playing, beat_tick, song_done, state
    );

    modport slave (
        input  play, pause, stop, loop_en, speed,
        output ibeatNum, part, playing, beat_tick, song_done, state
    );
endinterface

// File: rtl/beat_sequencer.sv
// Transport controller: divides clk into sub-beat ticks at a selectable tempo and
// steps the tone lookup index, looping with part toggling or parking on silence.
module beat_sequencer #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BEAT_FREQ = 8,
    parameter int BEAT_LEN  = 128
) (
    input  logic             clk,
    input  logic             rst,
    beat_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] T1       = 32'(CLK_FREQ / BEAT_FREQ);
    localparam logic [11:0] LAST_IDX = 12'(BEAT_LEN - 1);
    localparam logic [11:0] END_IDX  = 12'(BEAT_LEN);

    state_t      state_q, state_n;
    logic [31:0] cnt_q, cnt_n;
    logic [11:0] beat_q, beat_n;
    logic        part_q, part_n;
    logic        playing_q;
    logic        tick_q, tick_n;
    logic        done_q, done_n;
    logic [31:0] term;
    logic        advance;

    // Tempo terminal is re-evaluated every cycle so a speed change applies at once.
    always_comb begin
        case (bus.speed)
            2'b01:   term = T1 >> 1;
            2'b10:   term = T1 << 1;
            default: term = T1;
        endcase
    end

    // >= rather than == so a mid-count slowdown-to-faster switch advances immediately.
    assign advance = (cnt_q >= term - 32'd1);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        beat_n  = beat_q;
        part_n  = part_q;
        tick_n  = 1'b0;
        done_n  = 1'b0;
        if (bus.stop) begin
            state_n = IDLE;
            cnt_n   = '0;
            beat_n  = '0;
            part_n  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.play) begin
                        state_n = PLAY;
                        cnt_n   = '0;
                    end
                end
                PLAY: begin
                    if (bus.pause) begin
                        state_n = PAUSE;
                    end else if (advance) begin
                        cnt_n = '0;
                        if (beat_q < LAST_IDX) begin
                            beat_n = beat_q + 12'd1;
                            tick_n = 1'b1;
                        end else if (bus.loop_en) begin
                            beat_n = '0;
                            part_n = ~part_q;
                            tick_n = 1'b1;
                        end else begin
                            state_n = DONE;
                            beat_n  = END_IDX;
                            done_n  = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_q + 32'd1;
                    end
                end
                PAUSE: begin
                    if (bus.play) begin
                        state_n = PLAY;
                    end
                end
                DONE: begin
                    if (bus.play) begin
                        state_n = PLAY;
                        cnt_n   = '0;
                        beat_n  = '0;
                        part_n  = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            beat_q    <= '0;
            part_q    <= 1'b1;
            playing_q <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            beat_q    <= beat_n;
            part_q    <= part_n;
            playing_q <= (state_n == PLAY);
            tick_q    <= tick_n;
            done_q    <= done_n;
        end
    end

    assign bus.ibeatNum  = beat_q;
    assign bus.part      = part_q;
    assign bus.playing   = playing_q;
    assign bus.beat_tick = tick_q;
    assign bus.song_done = done_q;
    assign bus.state     = state_q;
endmodule
